sram_word_ctrl: RTL and testbench
=================================

Name: sram_word_ctrl

Overview:
- Downstream stage of the dual-core SRAM arbiter.
- Accepts one 32-bit word read or write per request on a 17-bit word address, split into two 16-bit accesses.
- Sequences the external 16-bit asynchronous SRAM pins for each access.
- Returns `busy` (the arbiter's `sram_status` stall) and the assembled read word.

Parameters:
- ADDR_W, 17, word address width from arbiter
- DATA_W, 32, word width; fixed at 2x SRAM_DW
- SRAM_AW, 18, external halfword address width; must equal ADDR_W+1
- SRAM_DW, 16, external data width
- WAIT_CYC, 1, extra cycles each half-access phase is held; must be >= 1

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- req_we  in  1  word write request, held until busy falls
- req_re  in  1  word read request, held until busy falls
- req_addr  in  ADDR_W  word address
- req_wd  in  DATA_W  write data
- busy  out  1  stall to arbiter/requester
- rd_data  out  DATA_W  last read word, held until next read completes
- rd_valid  out  1  one-cycle pulse in the DONE cycle of a read
- collision  out  1  sticky; set when req_we and req_re are both high at acceptance
- SRAM_A  out  SRAM_AW  halfword address
- SRAM_D  inout  SRAM_DW  data bus, driven only during write phases
- SRAM_CE_n, SRAM_OE_n, SRAM_WE_n, SRAM_LB_n, SRAM_UB_n  out  1 each  active-low strobes

Behaviour:
- Reset (async, immediate):
  - state=IDLE, wait counter=0
  - all strobes=1, SRAM_A=0, SRAM_D=Z
  - rd_data=0, rd_valid=0, collision=0
- States: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE. One-hot or binary, encoded in the package.
- IDLE:
  - req_we=1 -> WR_LO; else req_re=1 -> RD_LO. Write wins when both are high; collision<=1 in that case.
  - Latch req_addr, req_wd, and op type on acceptance.
  - busy = req_we|req_re (combinational in IDLE).
- Phase timing: each LO/HI phase lasts WAIT_CYC+1 cycles, counted by a wait counter that is cleared on phase entry.
- Address map:
  - LO phase: SRAM_A={addr,1'b0}, holds data bits [15:0].
  - HI phase: SRAM_A={addr,1'b1}, holds data bits [31:16].
  - SRAM_A is registered and stable for the whole phase.
- Strobes during any phase: CE_n=0, LB_n=0, UB_n=0.
- Read phase:
  - OE_n=0, WE_n=1, SRAM_D=Z.
  - SRAM_D is sampled on the last cycle of the phase into the lo/hi half register.
- Write phase:
  - OE_n=1; SRAM_D driven with the latched half for every cycle of the phase.
  - WE_n=0 on all cycles except the last, so WE_n rises with data and address still stable.
- Transitions:
  - RD_LO->RD_HI and WR_LO->WR_HI when the phase ends.
  - RD_HI/WR_HI->DONE when the phase ends.
  - DONE->IDLE unconditionally. The still-asserted request is never re-accepted in DONE.
- busy:
  - Always 1 in LO/HI states; 0 in DONE.
  - Total busy cycles per request = 1+2*(WAIT_CYC+1), i.e. 5 at the default.
- DONE cycle:
  - Strobes deasserted.
  - Reads: rd_data={hi,lo} is visible in this cycle, and rd_valid=1 for exactly this cycle.
- Back-to-back requests: a new request is accepted in the IDLE cycle right after DONE. This gives one idle bus cycle between words.
- Requester rule: address/data/op must stay stable while busy=1. Changes after acceptance are ignored, because the values are latched.
- Reset mid-write aborts immediately. A half-written word is permitted and is documented as undefined memory content.
- collision is cleared only by reset.

Decomposition:
- Package sram_pkg holds:
  - the state enum typedef
  - ADDR_W/DATA_W/SRAM_AW/SRAM_DW defaults
  - function busy_cycles(WAIT_CYC) for use by benches
- No sub-module; the SRAM_D tri-state is a single conditional assign inside the block.

Test Plan:
- Reset asserted mid-RD_HI -> same-cycle strobes=1, SRAM_D=Z, busy=0, rd_data=0.
- Write req_addr=0x00005, req_wd=0xDEADBEEF:
  - SRAM model gets 0xBEEF at A=0x0000A and 0xDEAD at A=0x0000B.
  - WE_n low for 1 cycle per phase; busy high exactly 5 cycles.
- Read the same address -> rd_data=0xDEADBEEF in the DONE cycle, rd_valid single pulse, busy 5 cycles.
- req_we=req_re=1 at addr 0x1FFFF with data 0x12345678:
  - Write performed at A=0x3FFFE/0x3FFFF; collision=1 and stays set.
  - A later read returns 0x12345678.
- Request held high through DONE, then a new read of addr 0 issued next cycle -> exactly two accesses observed, each 5 busy cycles, with 1 idle cycle between.
- WAIT_CYC=3 build -> each phase 4 cycles, busy 9 cycles, WE_n low 3 cycles per write phase.

Source files
------------

// File: rtl/sram_pkg.sv
// -----------------------------------------------------------------------------
// sram_pkg
// Shared definitions for the 32-bit-word to 16-bit asynchronous SRAM controller:
//   - default widths and phase wait length
//   - controller state encoding
//   - busy_cycles(): stall length of one word request for a given WAIT_CYC
// -----------------------------------------------------------------------------
package sram_pkg;

  localparam int ADDR_W_DEF   = 32'sd17;  // word address width from arbiter
  localparam int DATA_W_DEF   = 32'sd32;  // word width, two SRAM halfwords
  localparam int SRAM_AW_DEF  = 32'sd18;  // halfword address width, ADDR_W+1
  localparam int SRAM_DW_DEF  = 32'sd16;  // external data width
  localparam int WAIT_CYC_DEF = 32'sd1;   // extra cycles per half-access phase

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_LO = 3'd1,
    ST_RD_HI = 3'd2,
    ST_WR_LO = 3'd3,
    ST_WR_HI = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // Cycles busy stays high for one request: the accepting IDLE cycle plus two
  // phases of WAIT_CYC+1 cycles each.
  function automatic int busy_cycles(input int wait_cyc);
    return 32'sd1 + 32'sd2 * (wait_cyc + 32'sd1);
  endfunction

endpackage

// File: rtl/sram_word_ctrl.sv
// -----------------------------------------------------------------------------
// sram_word_ctrl
// Turns one 32-bit word read/write request into two 16-bit accesses on an
// external asynchronous SRAM (low half at {addr,0}, high half at {addr,1}).
//
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   req_we / req_re       word write / read request, held until busy falls
//   req_addr, req_wd      word address and write data, latched on acceptance
//   busy                  stall back to the requester
//   rd_data, rd_valid     last read word; one-cycle pulse when it completes
//   collision             sticky flag: write and read requested together
//   SRAM_A, SRAM_D        halfword address and bidirectional data bus
//   SRAM_*_n              active-low chip/output/write/byte strobes
// -----------------------------------------------------------------------------
module sram_word_ctrl
  import sram_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int SRAM_AW  = SRAM_AW_DEF,
  parameter int SRAM_DW  = SRAM_DW_DEF,
  parameter int WAIT_CYC = WAIT_CYC_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_we,
  input  logic               req_re,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [DATA_W-1:0]  req_wd,
  output logic               busy,
  output logic [DATA_W-1:0]  rd_data,
  output logic               rd_valid,
  output logic               collision,
  output logic [SRAM_AW-1:0] SRAM_A,
  inout  wire  [SRAM_DW-1:0] SRAM_D,
  output logic               SRAM_CE_n,
  output logic               SRAM_OE_n,
  output logic               SRAM_WE_n,
  output logic               SRAM_LB_n,
  output logic               SRAM_UB_n
);

  localparam int CNT_W = (WAIT_CYC < 32'sd1) ? 32'sd1 : $clog2(WAIT_CYC + 32'sd1);
  localparam logic [CNT_W-1:0] LAST_CNT     = CNT_W'(WAIT_CYC);
  localparam logic [CNT_W-1:0] PRE_LAST_CNT = CNT_W'(WAIT_CYC - 32'sd1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(32'sd1);
  localparam logic [CNT_W-1:0] CNT_ZERO     = CNT_W'(32'sd0);

  state_t               r_state;
  logic [CNT_W-1:0]     r_wcnt;
  logic [ADDR_W-1:0]    r_addr;
  logic [DATA_W-1:0]    r_wd;
  logic [SRAM_DW-1:0]   r_lo;
  logic [DATA_W-1:0]    r_rd_data;
  logic                 r_rd_valid;
  logic                 r_collision;
  logic [SRAM_AW-1:0]   r_sram_a;
  logic                 r_strb_n;   // CE_n, LB_n and UB_n always move together
  logic                 r_oe_n;
  logic                 r_we_n;
  logic                 r_d_oe;
  logic [SRAM_DW-1:0]   r_d_out;

  logic                 w_req;
  logic                 w_in_phase;
  logic                 w_in_wr;
  logic                 w_phase_end;
  logic                 w_busy;

  assign w_req       = req_we | req_re;
  assign w_in_wr     = (r_state == ST_WR_LO) || (r_state == ST_WR_HI);
  assign w_in_phase  = w_in_wr || (r_state == ST_RD_LO) || (r_state == ST_RD_HI);
  assign w_phase_end = (r_wcnt == LAST_CNT);

  // Stall: follows the request while idle, forced high through both phases.
  always_comb begin
    w_busy = 1'b0;
    if (reset) begin
      w_busy = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE:                               w_busy = w_req;
        ST_RD_LO, ST_RD_HI, ST_WR_LO, ST_WR_HI: w_busy = 1'b1;
        ST_DONE:                               w_busy = 1'b0;
        default:                               w_busy = 1'b0;
      endcase
    end
  end

  // Controller FSM: acceptance, phase sequencing and every registered pin.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_wcnt      <= CNT_ZERO;
      r_addr      <= {ADDR_W{1'b0}};
      r_wd        <= {DATA_W{1'b0}};
      r_lo        <= {SRAM_DW{1'b0}};
      r_rd_data   <= {DATA_W{1'b0}};
      r_rd_valid  <= 1'b0;
      r_collision <= 1'b0;
      r_sram_a    <= {SRAM_AW{1'b0}};
      r_strb_n    <= 1'b1;
      r_oe_n      <= 1'b1;
      r_we_n      <= 1'b1;
      r_d_oe      <= 1'b0;
      r_d_out     <= {SRAM_DW{1'b0}};
    end else begin
      r_rd_valid <= 1'b0;
      // Count through the phase; a write raises WE_n for the final cycle so
      // it rises while address and data are still held.
      if (w_in_phase && !w_phase_end) begin
        r_wcnt <= r_wcnt + CNT_ONE;
        if (w_in_wr && (r_wcnt == PRE_LAST_CNT)) begin
          r_we_n <= 1'b1;
        end
      end
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_addr   <= req_addr;
            r_wd     <= req_wd;
            r_wcnt   <= CNT_ZERO;
            r_sram_a <= {req_addr, 1'b0};
            r_strb_n <= 1'b0;
            if (req_we) begin
              r_state <= ST_WR_LO;
              r_oe_n  <= 1'b1;
              r_we_n  <= 1'b0;
              r_d_oe  <= 1'b1;
              r_d_out <= req_wd[SRAM_DW-1:0];
              if (req_re) begin
                r_collision <= 1'b1;
              end
            end else begin
              r_state <= ST_RD_LO;
              r_oe_n  <= 1'b0;
              r_we_n  <= 1'b1;
              r_d_oe  <= 1'b0;
            end
          end
        end
        ST_RD_LO: begin
          if (w_phase_end) begin
            r_lo     <= SRAM_D;
            r_wcnt   <= CNT_ZERO;
            r_sram_a <= {r_addr, 1'b1};
            r_state  <= ST_RD_HI;
          end
        end
        ST_RD_HI: begin
          if (w_phase_end) begin
            r_rd_data  <= {SRAM_D, r_lo};
            r_rd_valid <= 1'b1;
            r_wcnt     <= CNT_ZERO;
            r_strb_n   <= 1'b1;
            r_oe_n     <= 1'b1;
            r_state    <= ST_DONE;
          end
        end
        ST_WR_LO: begin
          if (w_phase_end) begin
            r_wcnt   <= CNT_ZERO;
            r_sram_a <= {r_addr, 1'b1};
            r_d_out  <= r_wd[DATA_W-1:SRAM_DW];
            r_we_n   <= 1'b0;
            r_state  <= ST_WR_HI;
          end
        end
        ST_WR_HI: begin
          if (w_phase_end) begin
            r_wcnt   <= CNT_ZERO;
            r_strb_n <= 1'b1;
            r_we_n   <= 1'b1;
            r_d_oe   <= 1'b0;
            r_state  <= ST_DONE;
          end
        end
        // The request is still high here; it must not be taken again.
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state  <= ST_IDLE;
          r_wcnt   <= CNT_ZERO;
          r_strb_n <= 1'b1;
          r_oe_n   <= 1'b1;
          r_we_n   <= 1'b1;
          r_d_oe   <= 1'b0;
        end
      endcase
    end
  end

  assign SRAM_D    = r_d_oe ? r_d_out : {SRAM_DW{1'bz}};
  assign SRAM_A    = r_sram_a;
  assign SRAM_CE_n = r_strb_n;
  assign SRAM_LB_n = r_strb_n;
  assign SRAM_UB_n = r_strb_n;
  assign SRAM_OE_n = r_oe_n;
  assign SRAM_WE_n = r_we_n;
  assign busy      = w_busy;
  assign rd_data   = r_rd_data;
  assign rd_valid  = r_rd_valid;
  assign collision = r_collision;

endmodule

// File: tb/tb_sram_word_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for sram_word_ctrl: pin-level SRAM model, word-level
// reference memory, scoreboards for halfword writes and read words.
module tb_sram_word_ctrl;

  localparam int WC  = 1;
  localparam int WC3 = 3;
  localparam int BUSY_EXP  = 1 + 2 * (WC + 1);
  localparam int BUSY_EXP3 = 1 + 2 * (WC3 + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_we, req_re;
  logic [16:0] req_addr;
  logic [31:0] req_wd;
  logic        busy, rd_valid, collision;
  logic [31:0] rd_data;
  logic [17:0] sram_a;
  wire  [15:0] sram_d;
  logic        ce_n, oe_n, we_n, lb_n, ub_n;

  sram_word_ctrl #(.WAIT_CYC(WC)) u_dut (
    .clk(clk), .reset(reset), .req_we(req_we), .req_re(req_re),
    .req_addr(req_addr), .req_wd(req_wd), .busy(busy), .rd_data(rd_data),
    .rd_valid(rd_valid), .collision(collision), .SRAM_A(sram_a), .SRAM_D(sram_d),
    .SRAM_CE_n(ce_n), .SRAM_OE_n(oe_n), .SRAM_WE_n(we_n),
    .SRAM_LB_n(lb_n), .SRAM_UB_n(ub_n)
  );

  // Second build with longer phases
  logic        r3_we, r3_re;
  logic [16:0] r3_addr;
  logic [31:0] r3_wd;
  logic        busy3, rd_valid3, coll3;
  logic [31:0] rd_data3;
  logic [17:0] a3;
  wire  [15:0] d3;
  logic        ce3, oe3, we3, lb3, ub3;

  sram_word_ctrl #(.WAIT_CYC(WC3)) u_dut3 (
    .clk(clk), .reset(reset), .req_we(r3_we), .req_re(r3_re),
    .req_addr(r3_addr), .req_wd(r3_wd), .busy(busy3), .rd_data(rd_data3),
    .rd_valid(rd_valid3), .collision(coll3), .SRAM_A(a3), .SRAM_D(d3),
    .SRAM_CE_n(ce3), .SRAM_OE_n(oe3), .SRAM_WE_n(we3),
    .SRAM_LB_n(lb3), .SRAM_UB_n(ub3)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- SRAM pin models ----------------
  logic [15:0] mem  [0:262143];
  logic [15:0] mem3 [0:262143];
  logic        tb_drv = 1'b0;
  logic [15:0] tb_pat = 16'hA5C3;

  assign sram_d = (ce_n === 1'b0 && oe_n === 1'b0 && we_n === 1'b1 && lb_n === 1'b0 && ub_n === 1'b0)
                  ? mem[sram_a] : (tb_drv ? tb_pat : 16'hzzzz);
  assign d3 = (ce3 === 1'b0 && oe3 === 1'b0 && we3 === 1'b1 && lb3 === 1'b0 && ub3 === 1'b0)
              ? mem3[a3] : 16'hzzzz;

  typedef struct packed { logic [17:0] a; logic [15:0] d; } hw_t;
  hw_t         wexp_q[$];
  logic [31:0] rexp_q[$];
  logic [31:0] ref_mem [int];
  logic        exp_coll = 1'b0;
  int          ce_falls = 0;

  // Halfword write lands when WE_n rises; compare against expected write order.
  always @(posedge we_n) begin
    if (reset === 1'b0 && ce_n === 1'b0) begin
      mem[sram_a] = sram_d;
      if (wexp_q.size() == 0) begin
        check("sram_write_unexpected", {14'd0, sram_a, sram_d}, 64'd0);
      end else begin
        hw_t e;
        e = wexp_q.pop_front();
        check("sram_write", {14'd0, sram_a, sram_d}, {14'd0, e.a, e.d});
      end
    end
  end

  always @(posedge we3) begin
    if (reset === 1'b0 && ce3 === 1'b0) mem3[a3] = d3;
  end

  always @(negedge ce_n) begin
    if (reset === 1'b0) ce_falls++;
  end

  // WE_n low-length per write phase, sampled mid-cycle.
  int we_low = 0;
  int we_low3 = 0;
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (we_n === 1'b0) we_low++;
      else if (we_low != 0) begin
        check("we_low_cycles", 64'(we_low), 64'(WC));
        we_low = 0;
      end
      if (we3 === 1'b0) we_low3++;
      else if (we_low3 != 0) begin
        check("we_low_cycles_w3", 64'(we_low3), 64'(WC3));
        we_low3 = 0;
      end
    end
  end

  // Read monitor: every rd_valid pulse consumes one expected word.
  logic prev_rv = 1'b0;
  always @(negedge clk) begin
    if (reset === 1'b0 && rd_valid === 1'b1) begin
      check("rd_valid_single", {63'd0, prev_rv}, 64'd0);
      if (rexp_q.size() == 0) begin
        check("rd_valid_unexpected", {32'd0, rd_data}, 64'd0);
      end else begin
        logic [31:0] e;
        e = rexp_q.pop_front();
        check("rd_data", {32'd0, rd_data}, {32'd0, e});
      end
    end
    prev_rv = (reset === 1'b0) ? rd_valid : 1'b0;
  end

  // ---------------- driver ----------------
  task automatic do_req(input logic we, input logic re, input logic [16:0] a,
                        input logic [31:0] d, input bit hold);
    int nb;
    @(negedge clk);
    req_we = we; req_re = re; req_addr = a; req_wd = d;
    if (we) begin
      wexp_q.push_back({a, 1'b0, d[15:0]});
      wexp_q.push_back({a, 1'b1, d[31:16]});
      ref_mem[int'(a)] = d;
      if (re) exp_coll = 1'b1;
    end else if (re) begin
      rexp_q.push_back(ref_mem[int'(a)]);
    end
    #1;
    check("idle_bus_before_accept", {63'd0, ce_n}, 64'd1);
    nb = 0;
    for (int k = 0; k < 64; k++) begin
      if (busy !== 1'b1) break;
      nb++;
      @(negedge clk);
      // Post-acceptance changes must be ignored.
      req_addr = 17'($urandom);
      req_wd   = $urandom;
    end
    check("busy_cycles", 64'(nb), 64'(BUSY_EXP));
    check("done_strobes", {59'd0, ce_n, oe_n, we_n, lb_n, ub_n}, 64'h1F);
    check("collision", {63'd0, collision}, {63'd0, exp_coll});
    if (!hold) begin
      req_we = 1'b0; req_re = 1'b0;
    end
  endtask

  logic [16:0] pool [6];
  int          cf0;
  int          nb3, nv3;
  logic [31:0] w3data;

  initial begin
    pool[0] = 17'h00000; pool[1] = 17'h1FFFF; pool[2] = 17'h00100;
    pool[3] = 17'h0ABCD; pool[4] = 17'h12345; pool[5] = 17'h1FFFE;
    reset = 1'b1; req_we = 1'b0; req_re = 1'b0; req_addr = 17'd0; req_wd = 32'd0;
    r3_we = 1'b0; r3_re = 1'b0; r3_addr = 17'd0; r3_wd = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_strobes", {59'd0, ce_n, oe_n, we_n, lb_n, ub_n}, 64'h1F);
    check("rst_addr", {46'd0, sram_a}, 64'd0);
    check("rst_outs", {29'd0, busy, rd_valid, collision, rd_data}, 64'd0);
    reset = 1'b0;

    // Directed write / read of 0xDEADBEEF at word 5
    do_req(1'b1, 1'b0, 17'h00005, 32'hDEADBEEF, 1'b0);
    check("mem_lo_0A", {48'd0, mem[18'h0000A]}, 64'hBEEF);
    check("mem_hi_0B", {48'd0, mem[18'h0000B]}, 64'hDEAD);
    do_req(1'b0, 1'b1, 17'h00005, 32'd0, 1'b0);

    // Simultaneous write+read: write wins, sticky collision
    do_req(1'b1, 1'b1, 17'h1FFFF, 32'h12345678, 1'b0);
    check("mem_lo_3FFFE", {48'd0, mem[18'h3FFFE]}, 64'h5678);
    check("mem_hi_3FFFF", {48'd0, mem[18'h3FFFF]}, 64'h1234);
    do_req(1'b0, 1'b1, 17'h1FFFF, 32'd0, 1'b0);

    // Request held through DONE, then new read of addr 0 in the next cycle
    cf0 = ce_falls;
    do_req(1'b1, 1'b0, 17'h00000, 32'hCAFE0123, 1'b1);
    do_req(1'b0, 1'b1, 17'h00000, 32'd0, 1'b0);
    check("b2b_access_count", 64'(ce_falls - cf0), 64'd2);

    // Randomised traffic
    for (int i = 0; i < 40; i++) begin
      int op, gap;
      bit hold;
      logic [16:0] a;
      a = pool[$urandom_range(0, 5)];
      op = $urandom_range(0, 2);
      gap = $urandom_range(0, 3);
      hold = (gap == 0) && ($urandom_range(0, 2) == 0);
      if (op == 1 && !ref_mem.exists(int'(a))) op = 0;
      case (op)
        0: do_req(1'b1, 1'b0, a, $urandom, hold);
        1: do_req(1'b0, 1'b1, a, $urandom, hold);
        default: do_req(1'b1, 1'b1, a, $urandom, hold);
      endcase
      if (!hold) repeat (gap) @(negedge clk);
    end
    check("collision_sticky", {63'd0, collision}, 64'd1);

    // Reset in the middle of a read's high phase
    do_req(1'b0, 1'b1, 17'h00005, 32'd0, 1'b0);
    @(negedge clk);
    req_re = 1'b1; req_addr = 17'h00005;
    repeat (3) @(negedge clk);
    req_re = 1'b0;
    check("in_rd_hi", {45'd0, sram_a, oe_n}, {45'd0, 18'h0000B, 1'b0});
    tb_drv = 1'b1;
    #2 reset = 1'b1;
    #1;
    check("midrst_strobes", {59'd0, ce_n, oe_n, we_n, lb_n, ub_n}, 64'h1F);
    check("midrst_bus_released", {48'd0, sram_d}, {48'd0, tb_pat});
    check("midrst_outs", {29'd0, busy, rd_valid, collision, rd_data}, 64'd0);
    tb_drv = 1'b0;
    exp_coll = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    do_req(1'b0, 1'b1, 17'h1FFFF, 32'd0, 1'b0);

    // WAIT_CYC=3 build: write then read one word
    w3data = $urandom;
    @(negedge clk);
    r3_we = 1'b1; r3_addr = 17'h0ABCD; r3_wd = w3data;
    #1;
    nb3 = 0;
    for (int k = 0; k < 64; k++) begin
      if (busy3 !== 1'b1) break;
      nb3++;
      @(negedge clk);
    end
    r3_we = 1'b0;
    check("busy_cycles_w3_wr", 64'(nb3), 64'(BUSY_EXP3));
    check("mem3_lo", {48'd0, mem3[{17'h0ABCD, 1'b0}]}, {48'd0, w3data[15:0]});
    check("mem3_hi", {48'd0, mem3[{17'h0ABCD, 1'b1}]}, {48'd0, w3data[31:16]});
    @(negedge clk);
    r3_re = 1'b1;
    #1;
    nb3 = 0; nv3 = 0;
    for (int k = 0; k < 64; k++) begin
      if (rd_valid3 === 1'b1) begin
        nv3++;
        check("rd_data_w3", {32'd0, rd_data3}, {32'd0, w3data});
      end
      if (busy3 !== 1'b1) break;
      nb3++;
      @(negedge clk);
    end
    r3_re = 1'b0;
    check("busy_cycles_w3_rd", 64'(nb3), 64'(BUSY_EXP3));
    check("rd_valid_w3_count", 64'(nv3), 64'd1);
    @(negedge clk);
    check("rd_valid_w3_low", {63'd0, rd_valid3}, 64'd0);
    check("coll3_clear", {63'd0, coll3}, 64'd0);

    repeat (4) @(negedge clk);
    check("pending_reads", 64'(rexp_q.size()), 64'd0);
    check("pending_writes", 64'(wexp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Absolute time bound so the bench can never hang.
  initial begin
    #200000;
    n_errors++;
    $display("FAIL timeout: got no finish expected finish");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "timeout");
  end

endmodule
